// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe shared definitions: LEGv8 opcodes, branch/ALU/writeback
// encodings and the ID/EX, EX/MEM, MEM/WB control bundles.
package ctrl_pipe_pkg;

    localparam int OPCODE_W = 11;
    localparam int REG_W    = 5;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;
    localparam logic [REG_W-1:0] LINK_REG = 5'd30;

    // Full 11-bit opcodes (R-format, D-format, BR)
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_ANDS = 11'b11101010000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;

    // I-format: opcode[10:1]
    localparam logic [9:0] OP_ADDI  = 10'b1001000100;
    localparam logic [9:0] OP_SUBI  = 10'b1101000100;
    localparam logic [9:0] OP_ANDI  = 10'b1001001000;
    localparam logic [9:0] OP_ORRI  = 10'b1011001000;
    localparam logic [9:0] OP_ADDIS = 10'b1011000100;
    localparam logic [9:0] OP_SUBIS = 10'b1111000100;
    localparam logic [9:0] OP_ANDIS = 10'b1111001000;

    // IM-format: opcode[10:2]
    localparam logic [8:0] OP_MOVZ = 9'b110100101;
    localparam logic [8:0] OP_MOVK = 9'b111100101;

    // CB-format: opcode[10:3]
    localparam logic [7:0] OP_CBZ   = 8'b10110100;
    localparam logic [7:0] OP_CBNZ  = 8'b10110101;
    localparam logic [7:0] OP_BCOND = 8'b01010100;

    // B-format: opcode[10:5]
    localparam logic [5:0] OP_B  = 6'b000101;
    localparam logic [5:0] OP_BL = 6'b100101;

    localparam logic [2:0] BCOND_OP_NONE = 3'd0;
    localparam logic [2:0] BCOND_OP_B    = 3'd1;
    localparam logic [2:0] BCOND_OP_BCND = 3'd2;
    localparam logic [2:0] BCOND_OP_CBZ  = 3'd3;
    localparam logic [2:0] BCOND_OP_CBNZ = 3'd4;
    localparam logic [2:0] BCOND_OP_BR   = 3'd5;
    localparam logic [2:0] BCOND_OP_BL   = 3'd6;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_R     = 2'b10;
    localparam logic [1:0] ALUOP_OTHER = 2'b11;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

    typedef struct packed {
        logic             aluSrc;
        logic             sregUp;
        logic [1:0]       aluOp;
        logic [2:0]       branchOp;
        logic             memRead;
        logic             memWrite;
        logic             regWrite;
        logic             wregLoc;
        logic [1:0]       memToReg;
        logic [REG_W-1:0] rd;
    } ctrl_t;

    typedef struct packed {
        logic  valid;
        ctrl_t ctrl;
    } id_ex_t;

    typedef struct packed {
        logic             valid;
        logic             memRead;
        logic             memWrite;
        logic             regWrite;
        logic             wregLoc;
        logic [1:0]       memToReg;
        logic [REG_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic             valid;
        logic             regWrite;
        logic             wregLoc;
        logic [1:0]       memToReg;
        logic [REG_W-1:0] rd;
    } mem_wb_t;

    // All-zero encodes NONE branch, ALUOp 00, rd 0
    localparam id_ex_t  ID_EX_BUBBLE  = '0;
    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_decode.sv
// ctrl_decode: combinational LEGv8 opcode to control-bundle decoder,
// plus the source-register usage flags feeding hazard detection.
module ctrl_decode
    import ctrl_pipe_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    rd,
    output ctrl_t               ctrl,
    output logic                reg2Loc,
    output logic                usesRn,
    output logic                usesSrc2
);

    logic rReg;
    logic rRegS;
    logic shiftOp;
    logic immR;
    logic immRS;
    logic immOS;
    logic immO;
    logic isLdur;
    logic isStur;
    logic isB;
    logic isBl;
    logic isBcond;
    logic isCbz;
    logic isCbnz;
    logic isBr;
    logic isMovz;
    logic isMovk;
    logic rFmtReg;

    assign rReg = (opcode == OP_ADD) | (opcode == OP_SUB)
                | (opcode == OP_AND) | (opcode == OP_ORR);
    assign rRegS = (opcode == OP_ADDS) | (opcode == OP_ANDS)
                 | (opcode == OP_SUBS);
    assign shiftOp = (opcode == OP_LSL) | (opcode == OP_LSR);

    assign immR  = (opcode[10:1] == OP_ADDI) | (opcode[10:1] == OP_SUBI);
    assign immRS = (opcode[10:1] == OP_SUBIS);
    assign immOS = (opcode[10:1] == OP_ADDIS) | (opcode[10:1] == OP_ANDIS);
    assign immO  = (opcode[10:1] == OP_ANDI) | (opcode[10:1] == OP_ORRI);

    assign isLdur  = (opcode == OP_LDUR);
    assign isStur  = (opcode == OP_STUR);
    assign isBr    = (opcode == OP_BR);
    assign isB     = (opcode[10:5] == OP_B);
    assign isBl    = (opcode[10:5] == OP_BL);
    assign isBcond = (opcode[10:3] == OP_BCOND);
    assign isCbz   = (opcode[10:3] == OP_CBZ);
    assign isCbnz  = (opcode[10:3] == OP_CBNZ);
    assign isMovz  = (opcode[10:2] == OP_MOVZ);
    assign isMovk  = (opcode[10:2] == OP_MOVK);

    always_comb begin
        ctrl          = '0;
        ctrl.aluOp    = ALUOP_OTHER;
        ctrl.branchOp = BCOND_OP_NONE;
        ctrl.rd       = rd;
        reg2Loc       = 1'b0;
        usesRn        = 1'b0;
        rFmtReg       = 1'b0;
        unique case (1'b1)
            rReg, rRegS: begin
                rFmtReg       = 1'b1;
                usesRn        = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.sregUp   = rRegS;
                ctrl.aluOp    = ALUOP_R;
            end
            shiftOp, immR, immRS: begin
                usesRn        = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.sregUp   = immRS;
                ctrl.aluOp    = ALUOP_R;
            end
            immOS, immO: begin
                usesRn        = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.sregUp   = immOS;
            end
            isLdur: begin
                usesRn        = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.memRead  = 1'b1;
                ctrl.memToReg = MEMTOREG_MEM;
                ctrl.aluOp    = ALUOP_MEM;
            end
            isStur: begin
                usesRn        = 1'b1;
                reg2Loc       = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.memWrite = 1'b1;
                ctrl.aluOp    = ALUOP_MEM;
            end
            isB: ctrl.branchOp = BCOND_OP_B;
            isBcond: ctrl.branchOp = BCOND_OP_BCND;
            isBl: begin
                ctrl.regWrite = 1'b1;
                ctrl.wregLoc  = 1'b1;
                ctrl.memToReg = MEMTOREG_PC;
                ctrl.branchOp = BCOND_OP_BL;
                ctrl.rd       = LINK_REG;
            end
            isCbz, isCbnz: begin
                usesRn        = 1'b1;
                reg2Loc       = 1'b1;
                ctrl.sregUp   = 1'b1;
                ctrl.branchOp = isCbz ? BCOND_OP_CBZ : BCOND_OP_CBNZ;
                ctrl.aluOp    = isCbz ? ALUOP_CBZ : ALUOP_OTHER;
            end
            isBr: begin
                usesRn        = 1'b1;
                reg2Loc       = 1'b1;
                ctrl.branchOp = BCOND_OP_BR;
                ctrl.aluOp    = ALUOP_R;
            end
            isMovz, isMovk: begin
                usesRn        = isMovk;
                reg2Loc       = isMovk;
                ctrl.regWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
            end
            default: ;
        endcase
        // XZR is never written
        if (ctrl.rd == ZERO_REG) begin
            ctrl.regWrite = 1'b0;
        end
        usesSrc2 = reg2Loc | rFmtReg;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined LEGv8 control with load-use stall and branch flush.
// Load-use detection and stall_cnt exist only with CTRL_LOAD_USE_STALL_EN.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rn,
    input  logic [REG_W-1:0]    id_rm,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                ex_branch_taken,
    output logic                id_reg2loc,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                ifid_flush,
    output logic                ex_valid,
    output logic                ex_alu_src,
    output logic                ex_sreg_up,
    output logic [1:0]          ex_alu_op,
    output logic [2:0]          ex_branch_op,
    output logic [REG_W-1:0]    ex_rd,
    output logic                mem_valid,
    output logic                mem_read,
    output logic                mem_write,
    output logic [REG_W-1:0]    mem_rd,
    output logic                wb_valid,
    output logic                wb_reg_write,
    output logic                wb_wreg_loc,
    output logic [1:0]          wb_mem_to_reg,
    output logic [REG_W-1:0]    wb_rd,
    output logic [CNT_W-1:0]    stall_cnt
);

    ctrl_t            idCtrl;
    logic             reg2Loc;
    logic             usesRn;
    logic             usesSrc2;
    logic             hazard;
    logic             stall;
    logic             flush;
    id_ex_t           idEx;
    id_ex_t           nextIdEx;
    ex_mem_t          exMem;
    mem_wb_t          memWb;
    logic [CNT_W-1:0] stallCnt;

    ctrl_decode uDecode (
        .opcode   (id_opcode),
        .rd       (id_rd),
        .ctrl     (idCtrl),
        .reg2Loc  (reg2Loc),
        .usesRn   (usesRn),
        .usesSrc2 (usesSrc2)
    );

`ifdef CTRL_LOAD_USE_STALL_EN
    logic [REG_W-1:0] src2;

    assign src2 = reg2Loc ? id_rd : id_rm;
    assign hazard = id_valid & idEx.valid & idEx.ctrl.memRead
                  & (idEx.ctrl.rd != ZERO_REG)
                  & ((usesRn & (idEx.ctrl.rd == id_rn))
                   | (usesSrc2 & (idEx.ctrl.rd == src2)));
`else
    logic unusedSrc;

    assign unusedSrc = ^{id_rn, id_rm, usesRn, usesSrc2};
    assign hazard = 1'b0;
`endif

    // Flush outranks stall
    assign flush = ex_branch_taken;
    assign stall = hazard & ~flush;

    assign id_reg2loc = reg2Loc;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign ifid_flush = flush;

    always_comb begin
        nextIdEx = ID_EX_BUBBLE;
        if (id_valid && !stall && !flush) begin
            nextIdEx.valid = 1'b1;
            nextIdEx.ctrl  = idCtrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idEx  <= ID_EX_BUBBLE;
            exMem <= EX_MEM_BUBBLE;
            memWb <= MEM_WB_BUBBLE;
        end else begin
            idEx  <= nextIdEx;
            exMem <= '{
                valid:    idEx.valid,
                memRead:  idEx.ctrl.memRead,
                memWrite: idEx.ctrl.memWrite,
                regWrite: idEx.ctrl.regWrite,
                wregLoc:  idEx.ctrl.wregLoc,
                memToReg: idEx.ctrl.memToReg,
                rd:       idEx.ctrl.rd
            };
            memWb <= '{
                valid:    exMem.valid,
                regWrite: exMem.regWrite,
                wregLoc:  exMem.wregLoc,
                memToReg: exMem.memToReg,
                rd:       exMem.rd
            };
        end
    end

    always_ff @(posedge clk) begin
`ifdef CTRL_LOAD_USE_STALL_EN
        if (rst) begin
            stallCnt <= '0;
        end else if (stall && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
`else
        stallCnt <= '0;
`endif
    end

    assign ex_valid      = idEx.valid;
    assign ex_alu_src    = idEx.ctrl.aluSrc;
    assign ex_sreg_up    = idEx.ctrl.sregUp;
    assign ex_alu_op     = idEx.ctrl.aluOp;
    assign ex_branch_op  = idEx.ctrl.branchOp;
    assign ex_rd         = idEx.ctrl.rd;
    assign mem_valid     = exMem.valid;
    assign mem_read      = exMem.memRead;
    assign mem_write     = exMem.memWrite;
    assign mem_rd        = exMem.rd;
    assign wb_valid      = memWb.valid;
    assign wb_reg_write  = memWb.regWrite;
    assign wb_wreg_loc   = memWb.wregLoc;
    assign wb_mem_to_reg = memWb.memToReg;
    assign wb_rd         = memWb.rd;
    assign stall_cnt     = stallCnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe; expected control bundles
// come from an opcode table and follow each instruction through EX/MEM/WB.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam int CNT_W = 8;
`ifdef CTRL_LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef enum {
        K_LDUR, K_ADD, K_STUR, K_B, K_BL,
        K_CBZ, K_MOVZ, K_SUBS, K_ADDI, K_UNK
    } kind_e;

    typedef struct packed {
        logic        aluSrc;
        logic        sregUp;
        logic [1:0]  aluOp;
        logic [2:0]  branchOp;
        logic [4:0]  rd;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
        logic        wregLoc;
        logic [1:0]  memToReg;
        logic        reg2loc;
        logic        usesRn;
        logic        usesSrc2;
        logic [31:0] acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid = 1'b0;
    logic [10:0]      id_opcode = '0;
    logic [4:0]       id_rn = '0;
    logic [4:0]       id_rm = '0;
    logic [4:0]       id_rd = '0;
    logic             ex_branch_taken = 1'b0;
    logic             id_reg2loc;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             ex_valid;
    logic             ex_alu_src;
    logic             ex_sreg_up;
    logic [1:0]       ex_alu_op;
    logic [2:0]       ex_branch_op;
    logic [4:0]       ex_rd;
    logic             mem_valid;
    logic             mem_read;
    logic             mem_write;
    logic [4:0]       mem_rd;
    logic             wb_valid;
    logic             wb_reg_write;
    logic             wb_wreg_loc;
    logic [1:0]       wb_mem_to_reg;
    logic [4:0]       wb_rd;
    logic [CNT_W-1:0] stall_cnt;

    ctrl_pipe #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .id_reg2loc      (id_reg2loc),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .ex_valid        (ex_valid),
        .ex_alu_src      (ex_alu_src),
        .ex_sreg_up      (ex_sreg_up),
        .ex_alu_op       (ex_alu_op),
        .ex_branch_op    (ex_branch_op),
        .ex_rd           (ex_rd),
        .mem_valid       (mem_valid),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_rd          (mem_rd),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_wreg_loc     (wb_wreg_loc),
        .wb_mem_to_reg   (wb_mem_to_reg),
        .wb_rd           (wb_rd),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    exp_t             exQ[$];
    exp_t             memQ[$];
    exp_t             wbQ[$];
    logic             lastValid = 1'b0;
    logic             lastMemRead = 1'b0;
    logic [4:0]       lastRd = '0;
    logic [CNT_W-1:0] expCnt = '0;

    function automatic logic [10:0] opOf(kind_e k);
        case (k)
            K_LDUR:  return 11'b11111000010;
            K_ADD:   return 11'b10001011000;
            K_STUR:  return 11'b11111000000;
            K_B:     return 11'b00010110101;
            K_BL:    return 11'b10010101100;
            K_CBZ:   return 11'b10110100011;
            K_MOVZ:  return 11'b11010010110;
            K_SUBS:  return 11'b11101011000;
            K_ADDI:  return 11'b10010001001;
            default: return 11'b00000000000;
        endcase
    endfunction

    function automatic exp_t expOf(kind_e k, logic [4:0] rd);
        exp_t e;
        e = '0;
        e.aluOp = 2'b11;
        e.branchOp = BCOND_OP_NONE;
        e.rd = rd;
        case (k)
            K_LDUR: begin
                e.regWrite = 1; e.aluSrc = 1; e.memRead = 1;
                e.memToReg = 2'b01; e.aluOp = 2'b00; e.usesRn = 1;
            end
            K_ADD: begin
                e.regWrite = 1; e.aluOp = 2'b10;
                e.usesRn = 1; e.usesSrc2 = 1;
            end
            K_SUBS: begin
                e.regWrite = 1; e.sregUp = 1; e.aluOp = 2'b10;
                e.usesRn = 1; e.usesSrc2 = 1;
            end
            K_ADDI: begin
                e.regWrite = 1; e.aluSrc = 1; e.aluOp = 2'b10;
                e.usesRn = 1;
            end
            K_STUR: begin
                e.reg2loc = 1; e.aluSrc = 1; e.memWrite = 1;
                e.aluOp = 2'b00; e.usesRn = 1; e.usesSrc2 = 1;
            end
            K_B: e.branchOp = BCOND_OP_B;
            K_BL: begin
                e.regWrite = 1; e.wregLoc = 1; e.memToReg = 2'b10;
                e.branchOp = BCOND_OP_BL; e.rd = 5'd30;
            end
            K_CBZ: begin
                e.reg2loc = 1; e.sregUp = 1; e.branchOp = BCOND_OP_CBZ;
                e.aluOp = 2'b01; e.usesRn = 1; e.usesSrc2 = 1;
            end
            K_MOVZ: begin
                e.regWrite = 1; e.aluSrc = 1;
            end
            default: ;
        endcase
        if (e.rd == 5'd31) e.regWrite = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic scoreboard();
        exp_t e;
        if (wb_valid) begin
            if (wbQ.size() == 0) check("wb_extra", wb_valid, 0);
            else begin
                e = wbQ.pop_front();
                check("wb_lat", cyc, e.acc + 3);
                check("wb_fields",
                      {wb_reg_write, wb_wreg_loc, wb_mem_to_reg, wb_rd},
                      {e.regWrite, e.wregLoc, e.memToReg, e.rd});
            end
        end
        if (mem_valid) begin
            if (memQ.size() == 0) check("mem_extra", mem_valid, 0);
            else begin
                e = memQ.pop_front();
                check("mem_lat", cyc, e.acc + 2);
                check("mem_fields", {mem_read, mem_write, mem_rd},
                      {e.memRead, e.memWrite, e.rd});
                wbQ.push_back(e);
            end
        end
        if (ex_valid) begin
            if (exQ.size() == 0) check("ex_extra", ex_valid, 0);
            else begin
                e = exQ.pop_front();
                check("ex_lat", cyc, e.acc + 1);
                check("ex_fields",
                      {ex_alu_src, ex_sreg_up, ex_alu_op, ex_branch_op, ex_rd},
                      {e.aluSrc, e.sregUp, e.aluOp, e.branchOp, e.rd});
                memQ.push_back(e);
            end
        end
    endtask

    task automatic issue(input kind_e k, input logic [4:0] rn, rm, rd,
                         input bit v, taken, r, output bit acc);
        exp_t e;
        bit haz;
        bit stl;
        logic [4:0] src2;
        @(negedge clk);
        rst = r;
        id_valid = v;
        id_opcode = opOf(k);
        id_rn = rn;
        id_rm = rm;
        id_rd = rd;
        ex_branch_taken = taken;
        e = expOf(k, rd);
        src2 = e.reg2loc ? rd : rm;
        haz = STALL_EN && v && lastValid && lastMemRead && (lastRd != 5'd31)
            && ((e.usesRn && lastRd == rn) || (e.usesSrc2 && lastRd == src2));
        stl = haz && !taken;
        #1;
        check("pc_write", pc_write, !stl);
        check("ifid_write", ifid_write, !stl);
        check("ifid_flush", ifid_flush, taken);
        check("id_reg2loc", id_reg2loc, e.reg2loc);
        acc = v && !stl && !taken && !r;
        e.acc = cyc;
        @(posedge clk);
        cyc++;
        #1;
        if (r) begin
            exQ.delete();
            memQ.delete();
            wbQ.delete();
            lastValid = 0;
            expCnt = '0;
        end else begin
            if (acc) exQ.push_back(e);
            lastValid = acc;
            lastMemRead = e.memRead;
            lastRd = e.rd;
            if (stl && expCnt != '1) expCnt = expCnt + 1'b1;
        end
        check("ex_valid", ex_valid, acc);
        scoreboard();
        check("stall_cnt", stall_cnt, expCnt);
    endtask

    task automatic feed(input kind_e k, input logic [4:0] rn, rm, rd,
                        output int tries);
        bit acc;
        acc = 0;
        tries = 0;
        for (int i = 0; i < 4 && !acc; i++) begin
            issue(k, rn, rm, rd, 1, 0, 0, acc);
            tries++;
        end
        check("feed_acc", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) issue(K_UNK, 0, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        int tries;
        bit acc;
        logic [CNT_W-1:0] cntBefore;
        logic [CNT_W-1:0] satExp;

        issue(K_UNK, 0, 0, 0, 0, 0, 1, acc);
        issue(K_UNK, 0, 0, 0, 0, 0, 1, acc);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_cnt", stall_cnt, 0);
        idle(1);

        feed(K_LDUR, 5'd2, 5'd0, 5'd1, tries);
        feed(K_ADD, 5'd1, 5'd4, 5'd3, tries);
        check("ld_add_tries", tries, STALL_EN ? 2 : 1);
        check("ld_add_cnt", stall_cnt, STALL_EN ? 1 : 0);

        feed(K_LDUR, 5'd2, 5'd0, 5'd31, tries);
        feed(K_ADD, 5'd31, 5'd4, 5'd3, tries);
        check("xzr_tries", tries, 1);

        feed(K_LDUR, 5'd9, 5'd0, 5'd5, tries);
        feed(K_STUR, 5'd6, 5'd0, 5'd5, tries);
        check("stur_tries", tries, STALL_EN ? 2 : 1);
        feed(K_LDUR, 5'd9, 5'd0, 5'd5, tries);
        feed(K_B, 5'd5, 5'd5, 5'd5, tries);
        check("b_tries", tries, 1);

        feed(K_BL, 5'd1, 5'd2, 5'd3, tries);
        feed(K_SUBS, 5'd7, 5'd8, 5'd9, tries);
        feed(K_ADDI, 5'd4, 5'd0, 5'd10, tries);
        feed(K_CBZ, 5'd0, 5'd0, 5'd12, tries);
        feed(K_MOVZ, 5'd0, 5'd0, 5'd13, tries);
        feed(K_UNK, 5'd1, 5'd2, 5'd14, tries);
        idle(3);

        feed(K_LDUR, 5'd2, 5'd0, 5'd7, tries);
        cntBefore = expCnt;
        issue(K_ADD, 5'd7, 5'd7, 5'd8, 1, 1, 0, acc);
        check("flush_cnt", stall_cnt, cntBefore);
        check("flush_exv", ex_valid, 0);
        idle(1);

        feed(K_LDUR, 5'd2, 5'd0, 5'd1, tries);
        issue(K_ADD, 5'd1, 5'd4, 5'd3, 1, 0, 1, acc);
        check("rst_stall_exv", ex_valid, 0);
        check("rst_stall_memv", mem_valid, 0);
        check("rst_stall_wbv", wb_valid, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_stall_pcw", pc_write, 1);
        feed(K_ADD, 5'd1, 5'd4, 5'd3, tries);
        check("rst_stall_tries", tries, 1);

        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            feed(K_LDUR, 5'd2, 5'd0, 5'd1, tries);
            feed(K_ADD, 5'd1, 5'd4, 5'd3, tries);
        end
        satExp = STALL_EN ? '1 : '0;
        check("cnt_sat", stall_cnt, satExp);

        idle(4);
        check("q_empty", exQ.size() + memQ.size() + wbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
